// File: rtl/crc_stream_engine.sv
// rtl/crc_stream_engine.sv - streaming CRC engine, runtime-configurable model, one registered CRC per packet
module crc_stream_engine #(
  parameter int CRC_W  = 8,
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CRC_W-1:0]      cfg_poly,
  input  logic [CRC_W-1:0]      cfg_init,
  input  logic [CRC_W-1:0]      cfg_xorout,
  input  logic                  cfg_refin,
  input  logic                  cfg_refout,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_W-1:0]     s_data,
  input  logic [DATA_W/8-1:0]   s_keep,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CRC_W-1:0]      m_crc
);
  localparam int NB = DATA_W / 8;
  localparam logic [NB-1:0] KEEP_ONE = NB'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CRC_W-1:0] crc_q, crc_d;
  logic [CRC_W-1:0] poly_q, poly_d;
  logic [CRC_W-1:0] xorout_q, xorout_d;
  logic             refin_q, refin_d;
  logic             refout_q, refout_d;
  logic             m_valid_q, m_valid_d;
  logic [CRC_W-1:0] m_crc_q, m_crc_d;

  logic             accept;
  logic             in_idle;
  logic [NB-1:0]    keep_eff;
  logic [CRC_W-1:0] eff_poly, eff_xorout, crc_start, crc_next, crc_final;
  logic             eff_refin, eff_refout;
  logic [7:0]       byte_b;

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  function automatic logic [CRC_W-1:0] rev_crc(input logic [CRC_W-1:0] c);
    logic [CRC_W-1:0] r;
    for (int i = 0; i < CRC_W; i++) r[i] = c[CRC_W-1-i];
    return r;
  endfunction

  assign s_ready  = rst_n && (state_q != DONE);
  assign accept   = s_valid && s_ready;
  assign keep_eff = s_last ? s_keep : '1;
  assign m_valid  = m_valid_q;
  assign m_crc    = m_crc_q;

  // The first beat of a packet runs on the live cfg_* inputs; later beats use the shadow copy.
  assign in_idle    = (state_q == IDLE);
  assign eff_poly   = in_idle ? cfg_poly   : poly_q;
  assign eff_xorout = in_idle ? cfg_xorout : xorout_q;
  assign eff_refin  = in_idle ? cfg_refin  : refin_q;
  assign eff_refout = in_idle ? cfg_refout : refout_q;
  assign crc_start  = in_idle ? cfg_init   : crc_q;

  always_comb begin
    crc_next = crc_start;
    byte_b   = '0;
    for (int i = 0; i < NB; i++) begin
      if (keep_eff[i]) begin
        byte_b = eff_refin ? rev8(s_data[8*i +: 8]) : s_data[8*i +: 8];
        crc_next[CRC_W-1 -: 8] = crc_next[CRC_W-1 -: 8] ^ byte_b;
        for (int k = 0; k < 8; k++) begin
          crc_next = crc_next[CRC_W-1] ? ((crc_next << 1) ^ eff_poly) : (crc_next << 1);
        end
      end
    end
    crc_final = (eff_refout ? rev_crc(crc_next) : crc_next) ^ eff_xorout;
  end

  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    poly_d    = poly_q;
    xorout_d  = xorout_q;
    refin_d   = refin_q;
    refout_d  = refout_q;
    m_valid_d = m_valid_q;
    m_crc_d   = m_crc_q;
    case (state_q)
      IDLE, RUN: begin
        if (accept) begin
          if (state_q == IDLE) begin
            poly_d   = cfg_poly;
            xorout_d = cfg_xorout;
            refin_d  = cfg_refin;
            refout_d = cfg_refout;
          end
          crc_d = crc_next;
          if (s_last) begin
            state_d   = DONE;
            m_valid_d = 1'b1;
            m_crc_d   = crc_final;
          end else begin
            state_d = RUN;
          end
        end
      end
      DONE: begin
        if (m_ready) begin
          state_d   = IDLE;
          m_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      crc_q     <= '0;
      poly_q    <= '0;
      xorout_q  <= '0;
      refin_q   <= 1'b0;
      refout_q  <= 1'b0;
      m_valid_q <= 1'b0;
      m_crc_q   <= '0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      poly_q    <= poly_d;
      xorout_q  <= xorout_d;
      refin_q   <= refin_d;
      refout_q  <= refout_d;
      m_valid_q <= m_valid_d;
      m_crc_q   <= m_crc_d;
    end
  end

  // Last-beat byte enables must form a run of ones starting at bit 0 (zero allowed).
  a_keep_contig: assert property (@(posedge clk) disable iff (!rst_n)
    (accept && s_last) |-> ((s_keep & (s_keep + KEEP_ONE)) == '0));

endmodule

// File: tb/tb_crc_stream_engine.sv
// tb/tb_crc_stream_engine.sv - self-checking bench for crc_stream_engine (8/8, 32/32 and 16/16 instances)
module tb_crc_stream_engine;
  typedef logic [7:0] byte_q_t[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] poly [3];
  logic [31:0] init [3];
  logic [31:0] xo [3];
  logic        refin [3];
  logic        refout [3];
  logic        s_valid [3];
  logic        s_last [3];
  logic        m_ready [3];
  logic [31:0] s_data [3];
  logic [3:0]  s_keep [3];
  logic        s_rdy [3];
  logic        m_vld [3];
  logic [31:0] m_crc [3];

  logic        rdy_a, rdy_b, rdy_c, mv_a, mv_b, mv_c;
  logic [7:0]  crc_a;
  logic [31:0] crc_b;
  logic [15:0] crc_c;

  assign s_rdy[0] = rdy_a;
  assign s_rdy[1] = rdy_b;
  assign s_rdy[2] = rdy_c;
  assign m_vld[0] = mv_a;
  assign m_vld[1] = mv_b;
  assign m_vld[2] = mv_c;
  assign m_crc[0] = {24'h0, crc_a};
  assign m_crc[1] = crc_b;
  assign m_crc[2] = {16'h0, crc_c};

  crc_stream_engine #(.CRC_W(8), .DATA_W(8)) u_a (
    .clk(clk), .rst_n(rst_n),
    .cfg_poly(poly[0][7:0]), .cfg_init(init[0][7:0]), .cfg_xorout(xo[0][7:0]),
    .cfg_refin(refin[0]), .cfg_refout(refout[0]),
    .s_valid(s_valid[0]), .s_ready(rdy_a), .s_data(s_data[0][7:0]),
    .s_keep(s_keep[0][0:0]), .s_last(s_last[0]),
    .m_valid(mv_a), .m_ready(m_ready[0]), .m_crc(crc_a));

  crc_stream_engine #(.CRC_W(32), .DATA_W(32)) u_b (
    .clk(clk), .rst_n(rst_n),
    .cfg_poly(poly[1]), .cfg_init(init[1]), .cfg_xorout(xo[1]),
    .cfg_refin(refin[1]), .cfg_refout(refout[1]),
    .s_valid(s_valid[1]), .s_ready(rdy_b), .s_data(s_data[1]),
    .s_keep(s_keep[1]), .s_last(s_last[1]),
    .m_valid(mv_b), .m_ready(m_ready[1]), .m_crc(crc_b));

  crc_stream_engine #(.CRC_W(16), .DATA_W(16)) u_c (
    .clk(clk), .rst_n(rst_n),
    .cfg_poly(poly[2][15:0]), .cfg_init(init[2][15:0]), .cfg_xorout(xo[2][15:0]),
    .cfg_refin(refin[2]), .cfg_refout(refout[2]),
    .s_valid(s_valid[2]), .s_ready(rdy_c), .s_data(s_data[2][15:0]),
    .s_keep(s_keep[2][1:0]), .s_last(s_last[2]),
    .m_valid(mv_c), .m_ready(m_ready[2]), .m_crc(crc_c));

  int          n_tests = 0;
  int          n_fail = 0;
  int          exp_push [3];
  int          exp_pop [3];
  logic [31:0] exp_val [3];

  function automatic int w_of(input int d);
    return (d == 0) ? 8 : ((d == 1) ? 32 : 16);
  endfunction

  function automatic int nb_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 4 : 2);
  endfunction

  function automatic logic [31:0] mask_of(input int w);
    return (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
  endfunction

  // Reference CRC: message bits shifted in one at a time against the register's top bit.
  function automatic logic [31:0] crc_model(input int w, input logic [31:0] p, input logic [31:0] i,
                                            input logic [31:0] x, input logic ri, input logic ro,
                                            input byte_q_t data);
    logic [31:0] m, c, r;
    logic        bi, fb;
    m = mask_of(w);
    c = i & m;
    for (int n = 0; n < data.size(); n++) begin
      for (int k = 0; k < 8; k++) begin
        bi = ri ? data[n][k] : data[n][7-k];
        fb = c[w-1] ^ bi;
        c  = (c << 1) & m;
        if (fb) c = c ^ (p & m);
      end
    end
    if (ro) begin
      r = '0;
      for (int k = 0; k < w; k++) r[k] = c[w-1-k];
      c = r;
    end
    return (c ^ x) & m;
  endfunction

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at %0t", name, d, act, exp, $time);
    end
  endtask

  task automatic set_cfg(input int d, input logic [31:0] p, input logic [31:0] i,
                         input logic [31:0] x, input logic ri, input logic ro);
    poly[d] = p; init[d] = i; xo[d] = x; refin[d] = ri; refout[d] = ro;
  endtask

  task automatic send_pkt(input int d, input byte_q_t data, input int gap, input bit tog, input int abort_at);
    int          nb, nbeats, rem, n;
    logic [31:0] expv;
    nb     = nb_of(d);
    nbeats = (data.size() == 0) ? 1 : (data.size() + nb - 1) / nb;
    expv   = crc_model(w_of(d), poly[d], init[d], xo[d], refin[d], refout[d], data);
    for (int bt = 0; bt < nbeats; bt++) begin
      if (bt == abort_at) begin
        s_valid[d] = 1'b0;
        return;
      end
      while (gap > 0 && $urandom_range(99) < gap) begin
        s_valid[d] = 1'b0;
        @(posedge clk); #1;
      end
      rem = data.size() - bt * nb;
      s_data[d] = $urandom;
      s_keep[d] = 4'($urandom);
      for (int j = 0; j < nb; j++)
        if (j < rem) s_data[d][8*j +: 8] = data[bt*nb + j];
      s_last[d] = (bt == nbeats - 1);
      if (s_last[d]) s_keep[d] = 4'((1 << rem) - 1);
      s_valid[d] = 1'b1;
      n = 0;
      @(negedge clk);
      if (gap == 0 && bt > 0) check("no_bubble", d, 32'(s_rdy[d]), 32'd1);
      while (!s_rdy[d] && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!s_rdy[d]) begin
        check("s_ready_timeout", d, 32'(s_rdy[d]), 32'd1);
        s_valid[d] = 1'b0;
        s_last[d]  = 1'b0;
        return;
      end
      @(posedge clk); #1;
      if (tog) begin
        poly[d] = $urandom; init[d] = $urandom; xo[d] = $urandom;
        refin[d] = 1'($urandom); refout[d] = 1'($urandom);
      end
      if (bt == nbeats - 1) begin
        exp_val[d] = expv;
        exp_push[d]++;
      end
    end
    s_valid[d] = 1'b0;
    s_last[d]  = 1'b0;
  endtask

  task automatic wait_result(input int d, input string name, input logic [31:0] lit);
    @(negedge clk);
    check({name, "_valid"}, d, 32'(m_vld[d]), 32'd1);
    check(name, d, m_crc[d], lit);
    @(posedge clk); #1;
  endtask

  task automatic run_lit(input int d, input logic [31:0] p, input logic [31:0] i, input logic [31:0] x,
                         input logic ri, input logic ro, input byte_q_t data,
                         input string name, input logic [31:0] lit);
    set_cfg(d, p, i, x, ri, ro);
    send_pkt(d, data, 0, 1'b0, -1);
    wait_result(d, name, lit);
  endtask

  task automatic compare_loop();
    logic        hold [3];
    logic [31:0] held [3];
    for (int d = 0; d < 3; d++) begin
      hold[d] = 1'b0;
      held[d] = '0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (!rst_n) check("s_ready_in_reset", d, 32'(s_rdy[d]), 32'd0);
        check("m_valid", d, 32'(m_vld[d]), 32'(exp_push[d] != exp_pop[d]));
        if (m_vld[d]) begin
          check("m_crc", d, m_crc[d], exp_val[d]);
          check("s_ready_while_valid", d, 32'(s_rdy[d]), 32'd0);
          if (hold[d]) check("m_crc_stable", d, m_crc[d], held[d]);
          if (m_ready[d] && exp_push[d] != exp_pop[d]) exp_pop[d]++;
        end
        hold[d] = m_vld[d] && !m_ready[d];
        held[d] = m_crc[d];
      end
    end
  endtask

  initial begin
    byte_q_t     msg, empty, rq;
    int          d, w, len;
    logic [31:0] m;
    for (int k = 0; k < 3; k++) begin
      set_cfg(k, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      s_valid[k] = 1'b0; s_last[k] = 1'b0; s_data[k] = '0; s_keep[k] = '0;
      m_ready[k] = 1'b1; exp_push[k] = 0; exp_pop[k] = 0; exp_val[k] = '0;
    end
    for (int k = 0; k < 9; k++) msg.push_back(8'(8'h31 + k));
    fork
      compare_loop();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("reset_m_valid", k, 32'(m_vld[k]), 32'd0);
      check("reset_m_crc", k, m_crc[k], 32'd0);
      check("reset_s_ready", k, 32'(s_rdy[k]), 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) check("s_ready_after_reset", k, 32'(s_rdy[k]), 32'd1);
    @(posedge clk); #1;

    check("model_smbus", 0, crc_model(8, 32'h07, 32'h00, 32'h00, 1'b0, 1'b0, msg), 32'hF4);
    check("model_rohc", 0, crc_model(8, 32'h07, 32'hFF, 32'h00, 1'b1, 1'b1, msg), 32'hD0);
    check("model_crc32", 1, crc_model(32, 32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, msg), 32'hCBF43926);
    check("model_ccitt", 2, crc_model(16, 32'h1021, 32'hFFFF, 32'h0, 1'b0, 1'b0, msg), 32'h29B1);

    run_lit(0, 32'h07, 32'h00, 32'h00, 1'b0, 1'b0, msg, "smbus", 32'hF4);
    run_lit(0, 32'h07, 32'hFF, 32'h00, 1'b1, 1'b1, msg, "rohc", 32'hD0);
    run_lit(0, 32'h1D, 32'hFF, 32'hFF, 1'b0, 1'b0, msg, "sae_j1850", 32'h4B);
    run_lit(0, 32'h9B, 32'hFF, 32'h00, 1'b0, 1'b0, empty, "cdma2000_empty", 32'hFF);
    run_lit(0, 32'h07, 32'h00, 32'h00, 1'b0, 1'b0, empty, "smbus_empty", 32'h00);
    run_lit(1, 32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, msg, "crc32", 32'hCBF43926);
    run_lit(2, 32'h1021, 32'hFFFF, 32'h0000, 1'b0, 1'b0, msg, "ccitt_false", 32'h29B1);

    set_cfg(0, 32'h07, 32'h00, 32'h00, 1'b0, 1'b0);
    send_pkt(0, msg, 0, 1'b1, -1);
    wait_result(0, "cfg_isolation", 32'hF4);

    set_cfg(0, 32'h07, 32'h00, 32'h00, 1'b0, 1'b0);
    send_pkt(0, msg, 50, 1'b0, -1);
    wait_result(0, "smbus_stalls", 32'hF4);
    set_cfg(1, 32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1);
    send_pkt(1, msg, 50, 1'b0, -1);
    wait_result(1, "crc32_stalls", 32'hCBF43926);

    m_ready[0] = 1'b0;
    set_cfg(0, 32'h07, 32'h00, 32'h00, 1'b0, 1'b0);
    send_pkt(0, msg, 0, 1'b0, -1);
    @(negedge clk);
    check("bp_first", 0, m_crc[0], 32'hF4);
    set_cfg(0, 32'h1D, 32'hFF, 32'hFF, 1'b0, 1'b0);
    fork
      send_pkt(0, msg, 0, 1'b0, -1);
      begin
        repeat (5) @(posedge clk);
        #1 m_ready[0] = 1'b1;
      end
    join
    wait_result(0, "bp_second", 32'h4B);

    set_cfg(0, 32'h07, 32'h00, 32'h00, 1'b0, 1'b0);
    send_pkt(0, msg, 0, 1'b0, 4);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    run_lit(0, 32'h07, 32'h00, 32'h00, 1'b0, 1'b0, msg, "after_reset", 32'hF4);

    for (int it = 0; it < 36; it++) begin
      d   = it % 3;
      w   = w_of(d);
      m   = mask_of(w);
      len = $urandom_range(64);
      rq.delete();
      for (int k = 0; k < len; k++) rq.push_back(8'($urandom));
      set_cfg(d, $urandom & m, $urandom & m, $urandom & m, 1'($urandom), 1'($urandom));
      send_pkt(d, rq, (it % 2 == 1) ? 30 : 0, 1'b0, -1);
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) check("drained", k, 32'(exp_push[k] - exp_pop[k]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
